// File: rtl/fmul_issue_arbiter_pkg.sv
// Shared types for the FMUL issue arbiter: S2E payload layout, FMUL op
// encoding and the killmask match helper.
// Ports: none (package).
package fmul_issue_arbiter_pkg;

  localparam int unsigned SPEC_STATES = 4;
  localparam int unsigned DATA_W      = 26;

  // FMUL operation classes; each has its own fixed execution latency
  typedef enum logic [1:0] {
    OP_FMUL_S  = 2'd0,
    OP_FMUL_D  = 2'd1,
    OP_FMADD_S = 2'd2,
    OP_FMADD_D = 2'd3
  } fmul_op_e;

  // Scheduler-to-execute payload as presented on the FMUL port
  typedef struct packed {
    fmul_op_e               op;
    logic [SPEC_STATES-1:0] killmask;
    logic [DATA_W-1:0]      data;
  } port_s2e_t;

  localparam int unsigned PORT_S2E_LEN = $bits(port_s2e_t);

  // A uop dies when an active kill hits any speculative state it depends on
  function automatic logic is_killed(input logic [SPEC_STATES-1:0] killmask,
                                     input logic                   kill_enable,
                                     input logic [SPEC_STATES-1:0] vkillmask);
    return kill_enable & (|(killmask & vkillmask));
  endfunction

endpackage

// File: rtl/fmul_issue_arbiter_if.sv
// Bundle of scheduler request, kill/flush and FMUL port signals.
// Ports (slave = arbiter view):
//   in : Flush, Kill_Enable, Kill_VKillMask, Req_Valid, Req_S2E, Fu_Ready
//   out: Req_Grant, Fu_Port_Valid, Fu_Port_S2E, Busy
interface fmul_issue_arbiter_if #(
  parameter int unsigned NUM_REQ = 2
);
  import fmul_issue_arbiter_pkg::*;

  logic                            Flush;
  logic                            Kill_Enable;
  logic [SPEC_STATES-1:0]          Kill_VKillMask;
  logic [NUM_REQ-1:0]              Req_Valid;
  logic [NUM_REQ*PORT_S2E_LEN-1:0] Req_S2E;
  logic [NUM_REQ-1:0]              Req_Grant;
  logic                            Fu_Port_Valid;
  logic [PORT_S2E_LEN-1:0]         Fu_Port_S2E;
  logic                            Fu_Ready;
  logic                            Busy;

  // Environment side: schedulers, kill/flush sources and the FMUL unit
  modport master (
    output Flush, Kill_Enable, Kill_VKillMask, Req_Valid, Req_S2E, Fu_Ready,
    input  Req_Grant, Fu_Port_Valid, Fu_Port_S2E, Busy
  );

  // Arbiter side
  modport slave (
    input  Flush, Kill_Enable, Kill_VKillMask, Req_Valid, Req_S2E, Fu_Ready,
    output Req_Grant, Fu_Port_Valid, Fu_Port_S2E, Busy
  );

endinterface

// File: rtl/fmul_issue_arbiter_rr_picker.sv
// Round-robin priority picker: first eligible index at or after rr_ptr,
// scanning upward modulo N.
// Ports: in eligible[N], rr_ptr; out grant_c (one-hot), idx_c, any_c.
module fmul_issue_arbiter_rr_picker #(
  parameter  int unsigned N     = 2,
  localparam int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     eligible,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [N-1:0]     grant_c,
  output logic [IDX_W-1:0] idx_c,
  output logic             any_c
);

  function automatic int unsigned wrap_idx(input int unsigned base,
                                           input int unsigned offs);
    int unsigned s;
    s = base + offs;
    return (s >= N) ? (s - N) : s;
  endfunction

  // Scan starting at the pointer; the first hit wins
  always_comb begin
    grant_c = '0;
    idx_c   = '0;
    any_c   = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!any_c && eligible[IDX_W'(wrap_idx(32'(rr_ptr), k))]) begin
        any_c                                      = 1'b1;
        grant_c[IDX_W'(wrap_idx(32'(rr_ptr), k))] = 1'b1;
        idx_c                                      = IDX_W'(wrap_idx(32'(rr_ptr), k));
      end
    end
  end

endmodule

// File: rtl/fmul_issue_arbiter.sv
// Shares one FMUL unit between NUM_REQ scheduler ports: round-robin pick,
// latch the winner's payload and hold it on the FMUL port until completion,
// flush or kill.
// Ports: clk, rst (sync, active-high); bus (slave modport) carrying
//   requests/grants, kill/flush, and the FMUL Port_Valid/Port_S2E/Ready.
module fmul_issue_arbiter
  import fmul_issue_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic                clk,
  input  logic                rst,
  fmul_issue_arbiter_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  state_e             state_q, state_d;
  port_s2e_t          payload_q, payload_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;

  port_s2e_t          req_c [NUM_REQ];
  logic [NUM_REQ-1:0] eligible_c;
  logic [NUM_REQ-1:0] pick_grant_c;
  logic [IDX_W-1:0]   pick_idx_c;
  logic               pick_any_c;
  logic               held_killed_c;
  logic               release_c;
  logic               grant_ok_c;
  logic               grant_c;

  // Unpack requests; a request hit by the active kill is not eligible
  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req_c[i]      = port_s2e_t'(bus.Req_S2E[i*PORT_S2E_LEN +: PORT_S2E_LEN]);
      eligible_c[i] = bus.Req_Valid[i] &
                      ~is_killed(req_c[i].killmask, bus.Kill_Enable, bus.Kill_VKillMask);
    end
  end

  fmul_issue_arbiter_rr_picker #(
    .N (NUM_REQ)
  ) u_rr_picker (
    .eligible (eligible_c),
    .rr_ptr   (rr_ptr_q),
    .grant_c  (pick_grant_c),
    .idx_c    (pick_idx_c),
    .any_c    (pick_any_c)
  );

  // Release frees the holding register this cycle, so a new grant may
  // land on the same edge for zero-bubble back-to-back issue
  always_comb begin
    held_killed_c = is_killed(payload_q.killmask, bus.Kill_Enable, bus.Kill_VKillMask);
    release_c     = bus.Flush | held_killed_c | ((state_q == ST_HOLD) & bus.Fu_Ready);
    grant_ok_c    = ~bus.Flush & ~rst & ((state_q == ST_IDLE) | release_c);
    grant_c       = grant_ok_c & pick_any_c;
  end

  assign bus.Req_Grant = grant_c ? pick_grant_c : '0;

  // Next state, payload and pointer
  always_comb begin
    state_d   = state_q;
    payload_d = payload_q;
    rr_ptr_d  = rr_ptr_q;
    if (grant_c) begin
      state_d   = ST_HOLD;
      payload_d = req_c[pick_idx_c];
      rr_ptr_d  = (pick_idx_c == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx_c + IDX_W'(1);
    end else if (release_c) begin
      state_d   = ST_IDLE;
    end
  end

  // State, holding register and round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      payload_q <= '0;
      rr_ptr_q  <= '0;
    end else begin
      state_q   <= state_d;
      payload_q <= payload_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

  // FMUL port is driven straight from flops
  assign bus.Fu_Port_Valid = (state_q == ST_HOLD);
  assign bus.Busy          = (state_q == ST_HOLD);
  assign bus.Fu_Port_S2E   = payload_q;

endmodule

// File: tb/tb_fmul_issue_arbiter.sv
// Testbench for fmul_issue_arbiter: directed scenarios with literal
// expectations, then randomized traffic checked against a behavioural model.
module tb_fmul_issue_arbiter;
  import fmul_issue_arbiter_pkg::*;

  localparam int N = 2;
  localparam int W = PORT_S2E_LEN;

  logic clk;
  logic rst;

  fmul_issue_arbiter_if #(.NUM_REQ(N)) bus ();

  fmul_issue_arbiter #(.NUM_REQ(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks;
  int n_err;

  // Model: what the FMUL port holds, the next round-robin start, cycles presented
  logic      m_known;
  logic      m_busy;
  port_s2e_t m_pay;
  int        m_ptr;
  int        m_cnt;

  // Observations of the last step for directed literal checks
  logic [N-1:0] obs_grant;
  logic         obs_valid;
  logic         obs_ready;
  logic [W-1:0] obs_s2e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int fmul_lat(input fmul_op_e op);
    case (op)
      OP_FMUL_S:  return 2;
      OP_FMUL_D:  return 3;
      OP_FMADD_S: return 6;
      default:    return 8;
    endcase
  endfunction

  function automatic port_s2e_t mk(input fmul_op_e op, input logic [SPEC_STATES-1:0] km,
                                   input logic [DATA_W-1:0] data);
    port_s2e_t p;
    p.op = op;
    p.killmask = km;
    p.data = data;
    return p;
  endfunction

  // One clock cycle: check registered outputs, drive inputs, check the grant,
  // then advance the model across the coming edge.
  task automatic step(input logic r, input logic f, input logic ke,
                      input logic [SPEC_STATES-1:0] vm, input logic [N-1:0] v,
                      input port_s2e_t p0, input port_s2e_t p1);
    port_s2e_t    p [N];
    logic [N-1:0] exp_g;
    logic         held_kill, ready, rel, allow;
    int           best, bestd, d;
    @(negedge clk);
    obs_valid = bus.Fu_Port_Valid;
    obs_s2e   = bus.Fu_Port_S2E;
    if (m_known) begin
      chk("fu_port_valid", 64'(obs_valid), 64'(m_busy));
      chk("busy", 64'(bus.Busy), 64'(m_busy));
      if (m_busy) chk("fu_port_s2e", 64'(obs_s2e), 64'(m_pay));
    end
    p[0] = p0;
    p[1] = p1;
    held_kill = ke && (|(m_pay.killmask & vm));
    // FMUL stand-in: ready on the last latency cycle, or at once on a kill
    if (m_busy) ready = (m_cnt == fmul_lat(m_pay.op) - 1) || held_kill;
    else        ready = 1'($urandom_range(0, 1));
    rst                = r;
    bus.Flush          = f;
    bus.Kill_Enable    = ke;
    bus.Kill_VKillMask = vm;
    bus.Req_Valid      = v;
    bus.Req_S2E        = {p1, p0};
    bus.Fu_Ready       = ready;
    #1;
    rel   = f || (m_busy && (held_kill || ready));
    allow = !r && !f && (!m_busy || rel);
    best  = -1;
    bestd = N;
    for (int i = 0; i < N; i++) begin
      if (v[i] && !(ke && (|(p[i].killmask & vm)))) begin
        d = (i - m_ptr + N) % N;
        if (d < bestd) begin
          bestd = d;
          best  = i;
        end
      end
    end
    exp_g = '0;
    if (allow && best >= 0) exp_g[best] = 1'b1;
    obs_grant = bus.Req_Grant;
    obs_ready = ready;
    chk("req_grant", 64'(obs_grant), 64'(exp_g));
    if (r) begin
      m_known = 1'b1;
      m_busy  = 1'b0;
      m_pay   = '0;
      m_ptr   = 0;
      m_cnt   = 0;
    end else if (exp_g != '0) begin
      m_busy = 1'b1;
      m_pay  = p[best];
      m_ptr  = (best + 1) % N;
      m_cnt  = 0;
    end else if (rel) begin
      m_busy = 1'b0;
      m_cnt  = 0;
    end else if (m_busy) begin
      m_cnt++;
    end
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, '0, '0, '0, '0);
  endtask

  initial begin
    port_s2e_t          a, b;
    logic [N-1:0]       exp_b [9];
    logic               r, f, ke;
    logic [SPEC_STATES-1:0] vm, km0, km1;
    n_checks = 0;
    n_err    = 0;
    m_known  = 1'b0;
    m_busy   = 1'b0;
    m_pay    = '0;
    m_ptr    = 0;
    m_cnt    = 0;
    rst                = 1'b1;
    bus.Flush          = 1'b0;
    bus.Kill_Enable    = 1'b0;
    bus.Kill_VKillMask = '0;
    bus.Req_Valid      = '0;
    bus.Req_S2E        = '0;
    bus.Fu_Ready       = 1'b0;

    // Single request, FMUL.S latency 2
    do_reset();
    a = mk(OP_FMUL_S, 4'h0, 26'h0000123);
    step(1'b0, 1'b0, 1'b0, '0, 2'b01, a, '0);
    chk("single_grant", 64'(obs_grant), 64'(2'b01));
    step(1'b0, 1'b0, 1'b0, '0, 2'b00, '0, '0);
    chk("single_valid_c1", 64'(obs_valid), 64'(1'b1));
    chk("single_ready_c1", 64'(obs_ready), 64'(1'b0));
    step(1'b0, 1'b0, 1'b0, '0, 2'b00, '0, '0);
    chk("single_valid_c2", 64'(obs_valid), 64'(1'b1));
    chk("single_ready_c2", 64'(obs_ready), 64'(1'b1));
    step(1'b0, 1'b0, 1'b0, '0, 2'b00, '0, '0);
    chk("single_idle_c3", 64'(obs_valid), 64'(1'b0));

    // Contention, FMUL.D latency 3: grants every 3 cycles, alternating
    do_reset();
    a = mk(OP_FMUL_D, 4'h0, 26'h00000aa);
    b = mk(OP_FMUL_D, 4'h0, 26'h00000bb);
    exp_b = '{2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00};
    for (int c = 0; c < 9; c++) begin
      step(1'b0, 1'b0, 1'b0, '0, 2'b11, a, b);
      chk("contend_grant", 64'(obs_grant), 64'(exp_b[c]));
      if (c > 0) chk("contend_no_bubble", 64'(obs_valid), 64'(1'b1));
    end

    // Kill of a held FMADD.D on port1; port0 granted in the same cycle
    do_reset();
    a = mk(OP_FMUL_S, 4'h0, 26'h0000c0);
    b = mk(OP_FMADD_D, 4'h4, 26'h0000c1);
    step(1'b0, 1'b0, 1'b0, '0, 2'b10, '0, b);
    chk("kill_held_first", 64'(obs_grant), 64'(2'b10));
    step(1'b0, 1'b0, 1'b0, '0, 2'b01, a, '0);
    step(1'b0, 1'b0, 1'b0, '0, 2'b01, a, '0);
    step(1'b0, 1'b0, 1'b1, 4'h4, 2'b01, a, '0);
    chk("kill_held_regrant", 64'(obs_grant), 64'(2'b01));
    step(1'b0, 1'b0, 1'b0, '0, 2'b00, '0, '0);
    chk("kill_held_new_s2e", 64'(obs_s2e), 64'(a));

    // Kill at arrival: port0 never granted while the kill is active
    do_reset();
    a = mk(OP_FMUL_S, 4'h2, 26'h0000d0);
    b = mk(OP_FMUL_S, 4'h0, 26'h0000d1);
    step(1'b0, 1'b0, 1'b1, 4'h2, 2'b11, a, b);
    chk("kill_arrival_grant", 64'(obs_grant), 64'(2'b10));
    for (int c = 0; c < 4; c++) begin
      step(1'b0, 1'b0, 1'b1, 4'h2, 2'b01, a, '0);
      chk("kill_arrival_none", 64'(obs_grant), 64'(2'b00));
    end

    // Flush during HOLD
    do_reset();
    a = mk(OP_FMUL_D, 4'h0, 26'h0000e0);
    b = mk(OP_FMUL_D, 4'h0, 26'h0000e1);
    step(1'b0, 1'b0, 1'b0, '0, 2'b11, a, b);
    step(1'b0, 1'b0, 1'b0, '0, 2'b11, a, b);
    step(1'b0, 1'b1, 1'b0, '0, 2'b11, a, b);
    chk("flush_grant", 64'(obs_grant), 64'(2'b00));
    step(1'b0, 1'b0, 1'b0, '0, 2'b11, a, b);
    chk("flush_valid_drop", 64'(obs_valid), 64'(1'b0));
    chk("flush_resume", 64'(obs_grant), 64'(2'b10));

    // Reset mid-HOLD: outputs clear, port0 wins first after reset
    a = mk(OP_FMADD_D, 4'h0, 26'h0000f0);
    b = mk(OP_FMADD_D, 4'h0, 26'h0000f1);
    step(1'b1, 1'b0, 1'b0, '0, 2'b11, a, b);
    chk("rst_grant", 64'(obs_grant), 64'(2'b00));
    step(1'b0, 1'b0, 1'b0, '0, 2'b11, a, b);
    chk("rst_valid", 64'(obs_valid), 64'(1'b0));
    chk("rst_s2e", 64'(obs_s2e), 64'(0));
    chk("rst_first_grant", 64'(obs_grant), 64'(2'b01));

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      r   = ($urandom_range(0, 99) < 2);
      f   = ($urandom_range(0, 99) < 4);
      ke  = ($urandom_range(0, 99) < 15);
      vm  = SPEC_STATES'($urandom_range(0, 15));
      km0 = ($urandom_range(0, 3) == 0) ? SPEC_STATES'($urandom_range(0, 15)) : '0;
      km1 = ($urandom_range(0, 3) == 0) ? SPEC_STATES'($urandom_range(0, 15)) : '0;
      a = mk(fmul_op_e'($urandom_range(0, 3)), km0, DATA_W'($urandom));
      b = mk(fmul_op_e'($urandom_range(0, 3)), km1, DATA_W'($urandom));
      step(r, f, ke, vm, N'($urandom_range(0, 3)), a, b);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
